// File: rtl/row_pingpong_buf.sv
// Previous-row line buffer: two single-port RAMs ping-pong between the row being written and the row being read.
// Defining ROW_BUF_STALL_CNT_EN adds a saturating counter of input stall cycles on stall_cnt.

module ram #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] din,
    output logic [DATA_BITS-1:0] dout
);
    logic [DATA_BITS-1:0] mem [2**ADDR_BITS];
    logic [DATA_BITS-1:0] dout_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= din;
            else    dout_q    <= mem[addr];
        end
    end

    assign dout = dout_q;
endmodule

module row_pingpong_buf #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_BITS:0]   line_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_cur,
    output logic [DATA_BITS-1:0] out_prev,
    output logic                 out_first_row,
    output logic                 out_last_col,
    output logic [31:0]          stall_cnt
);
    localparam logic [ADDR_BITS:0] MAX_LEN = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [ADDR_BITS:0] ONE     = {{ADDR_BITS{1'b0}}, 1'b1};

    typedef enum logic {IDLE, RUN} state_t;

    // Travels alongside the RAM read so the read data and its pixel meet in the same cycle.
    typedef struct packed {
        logic [DATA_BITS-1:0] cur;
        logic                 first;
        logic                 last;
        logic                 rbank;
    } side_t;

    typedef struct packed {
        logic [DATA_BITS-1:0] cur;
        logic [DATA_BITS-1:0] prev;
        logic                 first;
        logic                 last;
    } entry_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS:0]   len_q, len_d;
    logic [ADDR_BITS-1:0] col_q, col_d;
    logic                 row_first_q, row_first_d;
    logic                 bank_sel_q, bank_sel_d;
    logic                 pend_q, pend_d;
    side_t                side_q, side_d;
    logic [1:0]           qcnt_q, qcnt_d;
    logic [1:0]           rd_ptr_q, rd_ptr_d;
    logic [1:0]           wr_ptr_q, wr_ptr_d;
    entry_t               q_mem [3];

    logic                            run, accept, last_col, push, pop;
    logic [1:0][DATA_BITS-1:0]       bank_dout;
    entry_t                          push_entry, head;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign run      = (state_q == RUN);
    // Counting the in-flight read keeps a slot free for it even if the consumer stalls.
    assign in_ready = run && !start && (({1'b0, qcnt_q} + {2'b0, pend_q}) < 3'd3);
    assign accept   = in_valid && in_ready;
    assign last_col = ({1'b0, col_q} == (len_q - ONE));
    assign push     = pend_q && !start;
    assign out_valid = (qcnt_q != 2'd0);
    assign pop      = out_valid && out_ready;
    assign head     = q_mem[rd_ptr_q];

    assign out_cur       = out_valid ? head.cur   : '0;
    assign out_prev      = out_valid ? head.prev  : '0;
    assign out_first_row = out_valid && head.first;
    assign out_last_col  = out_valid && head.last;

    always_comb begin
        push_entry.cur   = side_q.cur;
        push_entry.prev  = side_q.first ? '0 : bank_dout[side_q.rbank];
        push_entry.first = side_q.first;
        push_entry.last  = side_q.last;
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        ram #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) u_ram (
            .clk  (clk),
            .en   (accept),
            .we   (accept && (bank_sel_q == 1'(b))),
            .addr (col_q),
            .din  (in_data),
            .dout (bank_dout[b])
        );
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        col_d       = col_q;
        row_first_d = row_first_q;
        bank_sel_d  = bank_sel_q;
        pend_d      = 1'b0;
        side_d      = side_q;
        qcnt_d      = qcnt_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        if (start) begin
            state_d     = RUN;
            len_d       = (line_len == '0 || line_len > MAX_LEN) ? MAX_LEN : line_len;
            col_d       = '0;
            row_first_d = 1'b1;
            bank_sel_d  = 1'b0;
            qcnt_d      = 2'd0;
            rd_ptr_d    = 2'd0;
            wr_ptr_d    = 2'd0;
        end else begin
            pend_d = accept;
            if (accept) begin
                side_d = '{cur: in_data, first: row_first_q, last: last_col, rbank: ~bank_sel_q};
                if (last_col) begin
                    col_d       = '0;
                    bank_sel_d  = ~bank_sel_q;
                    row_first_d = 1'b0;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            qcnt_d = qcnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= MAX_LEN;
            col_q       <= '0;
            row_first_q <= 1'b1;
            bank_sel_q  <= 1'b0;
            pend_q      <= 1'b0;
            side_q      <= '0;
            qcnt_q      <= 2'd0;
            rd_ptr_q    <= 2'd0;
            wr_ptr_q    <= 2'd0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            col_q       <= col_d;
            row_first_q <= row_first_d;
            bank_sel_q  <= bank_sel_d;
            pend_q      <= pend_d;
            side_q      <= side_d;
            qcnt_q      <= qcnt_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) q_mem[wr_ptr_q] <= push_entry;
    end

    assert property (@(posedge clk) disable iff (rst) !(push && !pop && qcnt_q == 2'd3));

`ifdef ROW_BUF_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (start)
            stall_cnt_d = '0;
        else if (run && in_valid && !in_ready && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_row_pingpong_buf.sv
// Scoreboard bench for row_pingpong_buf: a reference previous-row model predicts every output word.
module tb_row_pingpong_buf;
    localparam int AB = 8;
    localparam int DB = 16;

    logic          clk = 1'b0;
    logic          rst, start, in_valid, in_ready, out_valid, out_ready;
    logic          out_first_row, out_last_col;
    logic [AB:0]   line_len;
    logic [DB-1:0] in_data, out_cur, out_prev;
    logic [31:0]   stall_cnt;

    always #5 clk = ~clk;

    row_pingpong_buf #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
        .clk(clk), .rst(rst), .start(start), .line_len(line_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_cur(out_cur), .out_prev(out_prev),
        .out_first_row(out_first_row), .out_last_col(out_last_col),
        .stall_cnt(stall_cnt)
    );

    typedef struct packed {
        logic [DB-1:0] cur;
        logic [DB-1:0] prev;
        logic          first;
        logic          last;
    } exp_t;

    exp_t          sbq[$];
    logic [DB-1:0] prow [256];
    logic [DB-1:0] crow [256];
    int mlen = 256, mcol = 0, mrow = 0;
    int n_tests = 0, n_fail = 0;
    int cyc = 0, n_out = 0, n_last = 0, n_first = 0, stalls = 0;
    int first_acc_cyc = -1, first_out_cyc = -1;
    logic acc = 1'b0, running = 1'b0;
    logic [DB-1:0] lo_cur, lo_prev;

    // One clock: sample at the falling edge, update the model, return just after the rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        acc = in_valid && in_ready;
        if (!rst && out_valid && out_ready) begin
            n_out++;
            if (out_last_col) n_last++;
            if (out_first_row) n_first++;
            if (first_out_cyc < 0) first_out_cyc = cyc;
            lo_cur = out_cur;
            lo_prev = out_prev;
            n_tests++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL sb_extra: got cur=%h prev=%h, expected no output", out_cur, out_prev);
            end else begin
                e = sbq.pop_front();
                if (out_cur !== e.cur || out_prev !== e.prev ||
                    out_first_row !== e.first || out_last_col !== e.last) begin
                    n_fail++;
                    $display("FAIL sb_data: got cur=%h prev=%h first=%b last=%b, expected cur=%h prev=%h first=%b last=%b",
                             out_cur, out_prev, out_first_row, out_last_col, e.cur, e.prev, e.first, e.last);
                end
            end
        end
        if (running && !rst && !start && in_valid && !in_ready) stalls++;
        if (acc) begin
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            e.cur   = in_data;
            e.prev  = (mrow == 0) ? '0 : prow[mcol];
            e.first = (mrow == 0);
            e.last  = (mcol == mlen - 1);
            sbq.push_back(e);
            crow[mcol] = in_data;
            if (mcol == mlen - 1) begin
                mcol = 0;
                mrow++;
                prow = crow;
            end else mcol++;
        end
        if (rst) begin
            sbq.delete();
            running = 1'b0;
        end else if (start) begin
            sbq.delete();
            mlen = (line_len == 0 || line_len > 256) ? 256 : int'(line_len);
            mcol = 0;
            mrow = 0;
            stalls = 0;
            running = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        n_out = 0; n_last = 0; n_first = 0; first_acc_cyc = -1; first_out_cyc = -1;
    endtask

    task automatic do_start(input logic [AB:0] len);
        start = 1'b1; line_len = len; in_valid = 1'b0;
        step();
        start = 1'b0;
    endtask

    task automatic feed_word(input logic [DB-1:0] d, output int waits);
        waits = 0;
        in_valid = 1'b1; in_data = d;
        for (int i = 0; i < 64; i++) begin
            step();
            if (acc) break;
            waits++;
        end
        if (!acc) begin
            n_tests++; n_fail++;
            $display("FAIL feed_timeout: got no accept of %h, expected accept within 64 cycles", d);
        end
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 64 && sbq.size() != 0; i++) step();
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d words outstanding, expected 0", sbq.size());
        end
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        line_len = '0; in_data = '0;
        step(); step();
        rst = 1'b0; in_valid = 1'b1;
        #1;
        n_tests += 4;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        if ({out_cur, out_prev, out_first_row, out_last_col} !== '0) begin
            n_fail++;
            $display("FAIL rst_out_data: got cur=%h prev=%h first=%b last=%b expected zeros",
                     out_cur, out_prev, out_first_row, out_last_col);
        end
        if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_stall_cnt: got %0d expected 0", stall_cnt); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (acc) begin n_fail++; $display("FAIL idle_accept: got accept in IDLE, expected none"); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_basic();
        int w;
        out_ready = 1'b1;
        do_start(9'd4);
        clear_stats();
        for (int i = 0; i < 4; i++) feed_word(DB'(10 + i), w);
        for (int i = 0; i < 4; i++) feed_word(DB'(20 + i), w);
        drain();
        n_tests += 5;
        if (n_out != 8) begin n_fail++; $display("FAIL basic_count: got %0d expected 8", n_out); end
        if (first_out_cyc - first_acc_cyc != 2) begin
            n_fail++; $display("FAIL basic_latency: got %0d expected 2", first_out_cyc - first_acc_cyc);
        end
        if (n_last != 2) begin n_fail++; $display("FAIL basic_last_cnt: got %0d expected 2", n_last); end
        if (n_first != 4) begin n_fail++; $display("FAIL basic_first_cnt: got %0d expected 4", n_first); end
        if (lo_cur !== 16'd23 || lo_prev !== 16'd13) begin
            n_fail++; $display("FAIL basic_pair: got %0d/%0d expected 23/13", lo_cur, lo_prev);
        end
    endtask

    task automatic test_back_to_back();
        int w, tot;
        int last_out_cyc;
        tot = 0;
        out_ready = 1'b1;
        do_start(9'd8);
        clear_stats();
        for (int i = 0; i < 24; i++) begin
            feed_word(DB'(16'h0100 + i * 7), w);
            tot += w;
        end
        drain();
        last_out_cyc = first_out_cyc + 23;
        n_tests += 3;
        if (tot != 0) begin n_fail++; $display("FAIL b2b_ready: got %0d not-ready cycles expected 0", tot); end
        if (n_out != 24) begin n_fail++; $display("FAIL b2b_count: got %0d expected 24", n_out); end
        if (first_out_cyc - first_acc_cyc != 2 || cyc < last_out_cyc) begin
            n_fail++; $display("FAIL b2b_span: got first output %0d cycles after first accept expected 2",
                               first_out_cyc - first_acc_cyc);
        end
    endtask

    task automatic test_stall();
        int sent, lowcnt, acc_before, exp_stall;
        sent = 0; lowcnt = 0; acc_before = -1;
        out_ready = 1'b1;
        do_start(9'd8);
        clear_stats();
        for (int c = 0; c < 200 && sent < 8; c++) begin
            in_valid = 1'b1; in_data = DB'(16'h0300 + sent);
            if (n_out >= 1 && lowcnt < 12) begin out_ready = 1'b0; lowcnt++; end
            else out_ready = 1'b1;
            step();
            if (acc) sent++;
            else if (acc_before < 0) acc_before = sent;
        end
        drain();
`ifdef ROW_BUF_STALL_CNT_EN
        exp_stall = stalls;
`else
        exp_stall = 0;
`endif
        n_tests += 4;
        if (sent != 8) begin n_fail++; $display("FAIL stall_sent: got %0d expected 8", sent); end
        if (acc_before != 4) begin n_fail++; $display("FAIL stall_fill: got %0d accepts before stall expected 4", acc_before); end
        if (n_out != 8) begin n_fail++; $display("FAIL stall_count: got %0d expected 8", n_out); end
        if (stall_cnt !== 32'(exp_stall)) begin
            n_fail++; $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, exp_stall);
        end
    endtask

    task automatic test_len_zero();
        int w;
        out_ready = 1'b1;
        do_start(9'd0);
        clear_stats();
        for (int i = 0; i < 512; i++)
            feed_word((i < 256) ? DB'(16'h1000 + i) : DB'(16'h2000 + i - 256), w);
        drain();
        n_tests += 4;
        if (n_out != 512) begin n_fail++; $display("FAIL len0_count: got %0d expected 512", n_out); end
        if (n_last != 2) begin n_fail++; $display("FAIL len0_last_cnt: got %0d expected 2", n_last); end
        if (n_first != 256) begin n_fail++; $display("FAIL len0_first_cnt: got %0d expected 256", n_first); end
        if (lo_cur !== 16'h20FF || lo_prev !== 16'h10FF) begin
            n_fail++; $display("FAIL len0_col255: got %h/%h expected 20ff/10ff", lo_cur, lo_prev);
        end
    endtask

    task automatic test_restart();
        int w;
        out_ready = 1'b1;
        do_start(9'd4);
        for (int i = 0; i < 4; i++) feed_word(DB'(30 + i), w);
        for (int i = 0; i < 2; i++) feed_word(DB'(40 + i), w);
        do_start(9'd4);
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL restart_flush: got out_valid=%b expected 0", out_valid); end
        clear_stats();
        for (int i = 0; i < 4; i++) feed_word(DB'(50 + i), w);
        drain();
        n_tests += 3;
        if (n_out != 4) begin n_fail++; $display("FAIL restart_count: got %0d expected 4", n_out); end
        if (n_first != 4) begin n_fail++; $display("FAIL restart_first: got %0d expected 4", n_first); end
        if (lo_cur !== 16'd53 || lo_prev !== 16'd0) begin
            n_fail++; $display("FAIL restart_prev: got %0d/%0d expected 53/0", lo_cur, lo_prev);
        end
    endtask

    task automatic test_reset_midrow();
        int nacc;
        nacc = 0;
        out_ready = 1'b0;
        do_start(9'd8);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = DB'(16'h0500 + nacc);
            step();
            if (acc) nacc++;
        end
        n_tests += 2;
        if (nacc != 3) begin n_fail++; $display("FAIL full_accepts: got %0d expected 3", nacc); end
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid: got %b expected 1", out_valid); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        n_tests += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_ready: got %b expected 0", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if (acc || out_valid) begin
                n_fail++; $display("FAIL rstmid_idle: got accept=%b out_valid=%b expected 0/0", acc, out_valid);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_len_zero();
        test_restart();
        test_reset_midrow();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
